matmul_chain_ctrl: RTL
======================

// Module: matmul_chain_ctrl
// PURPOSE
//  Sequencer (initiator) for the two-stage matmul datapath: stage-1 multiplier -> temp BRAM -> stage-2 multiplier.
//  On start_i it drives, per output row, the stage-1 controls: clear, valid, k index, temp write.
//  It then drives the stage-2 pass (temp reads + valid) and pulses done_o when the stage-2 result is final.
//  Operand memories are addressed externally via row_idx_o / k_idx_o.
// PARAMETERS
//  K_LEN    8   stage-1 accumulation beats per row (din1/din2 beats)
//  ADDR_W   3   temp BRAM address width
//  ROWS     8   rows written to temp BRAM = stage-2 beats; 1..2**ADDR_W
//  TIMEOUT  64  max cycles waiting for done_i before error
// PORTS
//  clk_i           in   1       clock, rising edge
//  rstn_i          in   1       async active-low reset
//  start_i         in   1       start request; sampled in IDLE only
//  done_i          in   1       datapath done (stage-1 or stage-2, per state)
//  busy_o          out  1       high in every state except IDLE
//  en_o            out  1       datapath enable; equals busy_o
//  clear_o         out  1       accumulator clear, 1-cycle pulse
//  valid_o         out  1       operand beat valid to multiplier
//  k_idx_o         out  ADDR_W+ stage-1 beat index; width clog2(K_LEN)
//  row_idx_o       out  ADDR_W  current stage-1 row
//  wr_temp_en_o    out  1       temp BRAM write strobe
//  wr_temp_addr_o  out  ADDR_W  temp write address (= row_idx_o)
//  rd_temp_en_o    out  1       temp BRAM read strobe
//  rd_temp_addr_o  out  ADDR_W  temp read address
//  done_o          out  1       1-cycle pulse: full chain complete
//  err_o           out  1       sticky done_i timeout flag
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs and counters 0; err_o cleared.
//  All outputs are registered; no combinational path from inputs to outputs.
//  FSM (one state per cycle unless noted):
//   IDLE : start_i=1 -> CLR1; clears err_o, row=0.
//   CLR1 : clear_o=1 -> FEED1.
//   FEED1: K_LEN cycles, valid_o=1, k_idx_o=0..K_LEN-1 -> WAIT1.
//   WAIT1: valid_o=0. done_i=1 -> WRITE.
//          Wait counter reaching TIMEOUT -> err_o=1, go to IDLE (no done_o).
//   WRITE: wr_temp_en_o=1, wr_temp_addr_o=row.
//          If row==ROWS-1 -> CLR2; else row+1 -> CLR1.
//   CLR2 : clear_o=1 -> FEED2.
//   FEED2: ROWS cycles, rd_temp_en_o=1, rd_temp_addr_o=0..ROWS-1.
//          valid_o is the read strobe delayed 1 cycle (BRAM read latency 1).
//   FLUSH: 1 cycle; carries the last delayed valid_o -> WAIT2.
//   WAIT2: same rules as WAIT1 -> FIN.
//   FIN  : done_o=1 for 1 cycle -> IDLE.
//  Additional rules:
//   - start_i is ignored while busy_o=1; no queueing.
//   - done_i is ignored outside WAIT1/WAIT2, including while valid_o=1.
//   - The wait counter resets on entry to each WAIT state. Timeout fires on the TIMEOUT-th cycle without done_i.
//   - done_i and timeout in the same cycle: done_i wins.
//   - row, k and read-address counters never wrap mid-pass. Each resets to 0 at the start of its pass.
//   - wr_temp_en_o and rd_temp_en_o are never high in the same cycle.
//   - Reset mid-operation aborts immediately; no done_o; next start_i runs a full sequence.
// TESTING
//  1. Defaults; model asserts done_i on 3rd WAIT cycle; pulse start_i ->
//     busy_o high exactly 118 cycles; 8 WRITE strobes at addr 0..7; one done_o pulse; err_o=0.
//  2. In FEED2, check rd_temp_addr_o = 0..7 on consecutive cycles and valid_o high exactly 1 cycle later each beat ->
//     8 valid beats, last during FLUSH.
//  3. done_i never asserted -> after 1+8+64 cycles err_o=1, busy_o=0, no wr_temp_en_o, no done_o.
//     Re-start clears err_o.
//  4. start_i held high throughout a run, plus done_i pulsed during FEED1 ->
//     no restart mid-run, spurious done_i ignored, timing identical to scenario 1.
//  5. rstn_i low during row 3 WAIT1 -> all outputs 0 asynchronously.
//     Next start_i writes addr 0 first.
//  6. ROWS=1, K_LEN=1 -> sequence CLR1,FEED1,WAIT1,WRITE,CLR2,FEED2,FLUSH,WAIT2,FIN; rd_temp_addr_o=0 only.

Source files
------------

// File: rtl/matmul_chain_ctrl.sv
// Sequencer for the two-stage matmul chain: stage-1 multiplier -> temp BRAM
// -> stage-2 multiplier. For each row it drives clear, K_LEN operand beats,
// waits for the datapath done and writes temp. It then drives a stage-2
// read pass over temp and pulses done_o when the stage-2 result is final.
//
// Handshake: valid_o marks an operand beat that the multiplier consumes
// unconditionally, so there is no ready. done_i is a level that is sampled
// only in WAIT1/WAIT2 and is ignored everywhere else.
//
// Every output is a flop. Output flops are loaded from the next-state values,
// so they line up with the state register and no input reaches an output
// combinationally.
module matmul_chain_ctrl #(
  parameter int K_LEN   = 8,
  parameter int ADDR_W  = 3,
  parameter int ROWS    = 8,
  parameter int TIMEOUT = 64,
  localparam int KW     = (K_LEN > 1) ? $clog2(K_LEN) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              done_i,
  output logic              busy_o,
  output logic              en_o,
  output logic              clear_o,
  output logic              valid_o,
  output logic [KW-1:0]     k_idx_o,
  output logic [ADDR_W-1:0] row_idx_o,
  output logic              wr_temp_en_o,
  output logic [ADDR_W-1:0] wr_temp_addr_o,
  output logic              rd_temp_en_o,
  output logic [ADDR_W-1:0] rd_temp_addr_o,
  output logic              done_o,
  output logic              err_o,
  output logic [3:0]        dbg_state_o
);

  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CLR1  = 4'd1;
  localparam logic [3:0] S_FEED1 = 4'd2;
  localparam logic [3:0] S_WAIT1 = 4'd3;
  localparam logic [3:0] S_WRITE = 4'd4;
  localparam logic [3:0] S_CLR2  = 4'd5;
  localparam logic [3:0] S_FEED2 = 4'd6;
  localparam logic [3:0] S_FLUSH = 4'd7;
  localparam logic [3:0] S_WAIT2 = 4'd8;
  localparam logic [3:0] S_FIN   = 4'd9;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [KW-1:0]     k_q, k_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              clear_q, clear_d;
  logic              valid_q, valid_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              done_q, done_d;

  // Next-state and counter logic. The k, read-address and wait counters rest
  // at 0 outside their own state, so each pass starts from 0.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = '0;
    rd_d    = '0;
    wait_d  = '0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLR1;
          err_d   = 1'b0;
          row_d   = '0;
        end
      end
      S_CLR1:  state_d = S_FEED1;
      S_FEED1: begin
        if (k_q == KW'(K_LEN - 1)) state_d = S_WAIT1;
        else                       k_d     = k_q + 1'b1;
      end
      S_WAIT1, S_WAIT2: begin
        if (done_i) begin
          state_d = (state_q == S_WAIT1) ? S_WRITE : S_FIN;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (row_q == ADDR_W'(ROWS - 1)) begin
          state_d = S_CLR2;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_CLR1;
        end
      end
      S_CLR2:  state_d = S_FEED2;
      S_FEED2: begin
        if (rd_q == ADDR_W'(ROWS - 1)) state_d = S_FLUSH;
        else                           rd_d    = rd_q + 1'b1;
      end
      S_FLUSH: state_d = S_WAIT2;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state. The stage-2 valid is the read strobe
  // delayed by one cycle to cover the BRAM read latency.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    clear_d = (state_d == S_CLR1) || (state_d == S_CLR2);
    wr_en_d = (state_d == S_WRITE);
    rd_en_d = (state_d == S_FEED2);
    done_d  = (state_d == S_FIN);
    valid_d = (state_d == S_FEED1) || rd_en_q;
  end

  // State, counters and output flops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      k_q     <= '0;
      rd_q    <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
      valid_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      clear_q <= clear_d;
      valid_q <= valid_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  assign busy_o         = busy_q;
  assign en_o           = busy_q;
  assign clear_o        = clear_q;
  assign valid_o        = valid_q;
  assign k_idx_o        = k_q;
  assign row_idx_o      = row_q;
  assign wr_temp_en_o   = wr_en_q;
  assign wr_temp_addr_o = row_q;
  assign rd_temp_en_o   = rd_en_q;
  assign rd_temp_addr_o = rd_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign dbg_state_o    = state_q;

endmodule
